// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake on both sides.
// It holds one operation in flight. Single-cycle ops finish one edge after
// accept. MUL/MULHU use an iterative shift-add multiplier and finish XLEN
// edges after accept. An undecodable op sets a sticky exception code.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (op, in1, in2, shamt captured on accept)
//   out_valid/out_ready output handshake, out is the registered result
//   clear_err           clears the sticky exception register x31
//   x31                 exception code: 0 none, 2 undecodable op
module alu_pipe #(
   parameter int XLEN = 32,
   localparam int SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      op,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic [SHW-1:0]  shamt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   input  logic            clear_err,
   output logic [31:0]     x31
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic [31:0]       x31_q, x31_d;
   // Product register: upper half accumulates, lower half holds the
   // remaining multiplier bits and shifts right one bit per step.
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic              hi_q, hi_d;

   logic              accept_s;
   logic              is_mul_s;
   logic              illegal_s;
   logic              mul_last_s;
   logic [XLEN-1:0]   alu_res_s;
   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_step_s;

   assign accept_s   = in_valid && in_ready;
   assign is_mul_s   = (op == 6'd19) || (op == 6'd20);
   assign illegal_s  = (op > 6'd20);
   assign mul_last_s = (cnt_q == SHW'(XLEN - 1));

   // Single-cycle ALU result for the op currently offered.
   always_comb begin
      alu_res_s = {XLEN{1'b0}};
      case (op)
         6'd0, 6'd9:   alu_res_s = in1 + in2;
         6'd10:        alu_res_s = in1 - in2;
         // Comparisons are intentionally in2 > in1.
         6'd1, 6'd12:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in2) > $signed(in1))};
         6'd2, 6'd13:  alu_res_s = {{(XLEN-1){1'b0}}, (in2 > in1)};
         6'd3, 6'd14:  alu_res_s = in1 ^ in2;
         6'd4, 6'd17:  alu_res_s = in1 | in2;
         6'd5, 6'd18:  alu_res_s = in1 & in2;
         6'd6:         alu_res_s = in1 << shamt;
         6'd7:         alu_res_s = in1 >> shamt;
         6'd8:         alu_res_s = XLEN'($signed(in1) >>> shamt);
         6'd11:        alu_res_s = in1 << in2[SHW-1:0];
         6'd15:        alu_res_s = in1 >> in2[SHW-1:0];
         6'd16:        alu_res_s = XLEN'($signed(in1) >>> in2[SHW-1:0]);
         default:      alu_res_s = {XLEN{1'b0}};
      endcase
   end

   // One shift-add step: add multiplicand if the current multiplier bit is set,
   // then shift the whole product right (carry enters the top bit).
   always_comb begin
      mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      mul_step_s = {mul_sum_s, prod_q[XLEN-1:1]};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = is_mul_s ? ST_BUSY : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mul_last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (accept_s) begin
               state_d = is_mul_s ? ST_BUSY : ST_DONE;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; in DONE a new op is taken only when the result leaves.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: in_ready = 1'b0;
         ST_DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath next-state: capture on accept, iterate the multiplier in BUSY.
   always_comb begin
      out_d   = out_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      if (accept_s) begin
         if (is_mul_s) begin
            prod_d  = {{XLEN{1'b0}}, in2};
            mcand_d = in1;
            cnt_d   = {SHW{1'b0}};
            hi_d    = (op == 6'd20);
         end else begin
            out_d = alu_res_s;
         end
      end else if (state_q == ST_BUSY) begin
         prod_d = mul_step_s;
         if (mul_last_s) begin
            cnt_d = {SHW{1'b0}};
            out_d = hi_q ? mul_step_s[2*XLEN-1:XLEN] : mul_step_s[XLEN-1:0];
         end else begin
            cnt_d = cnt_q + SHW'(1);
         end
      end else begin
         out_d = out_q;
      end
   end

   // Sticky exception: a new undecodable op beats a coincident clear.
   always_comb begin
      if (accept_s && illegal_s) begin
         x31_d = 32'd2;
      end else if (clear_err) begin
         x31_d = 32'd0;
      end else begin
         x31_d = x31_q;
      end
   end

   // Datapath and exception registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q   <= {XLEN{1'b0}};
         prod_q  <= {(2*XLEN){1'b0}};
         mcand_q <= {XLEN{1'b0}};
         cnt_q   <= {SHW{1'b0}};
         hi_q    <= 1'b0;
         x31_q   <= 32'd0;
      end else begin
         out_q   <= out_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         x31_q   <= x31_d;
      end
   end

   assign out = out_q;
   assign x31 = x31_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a scoreboard queue: stimulus pushes the
// hand-computed result at accept, a monitor pops and compares on each transfer.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        clear_err;
   logic [31:0] x31;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_q[$];

   alu_pipe #(.XLEN(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .clear_err (clear_err),
      .x31       (x31)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Scoreboard monitor: compare each transferred result with the queue head.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got %h expected none", out);
         end else begin
            check("result", out, exp_q.pop_front());
         end
      end
   end

   // Offer one op, wait for acceptance; returns at accept edge + 1.
   task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic push, input logic [31:0] exp,
                        output int waits);
      op = o; in1 = a; in2 = b; shamt = sh; in_valid = 1'b1;
      waits = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         waits++;
         if (waits > 100) begin
            n_total++;
            $display("FAIL accept_timeout: got waits %0d expected <= 100", waits);
            in_valid = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      int w, w2, n;
      logic busy_ok;
      reset = 1'b1; in_valid = 1'b0; op = 6'd0; in1 = 32'd0; in2 = 32'd0;
      shamt = 5'd0; out_ready = 1'b1; clear_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_x31", x31, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: add wrap and subtract
      issue(6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 32'd0, w);
      check("add_latency", {31'd0, out_valid}, 32'd1);
      issue(6'd10, 32'd5, 32'd7, 5'd0, 1'b1, 32'hFFFF_FFFE, w);
      check("sub_latency", {31'd0, out_valid}, 32'd1);

      // 2: back-to-back compares
      issue(6'd1, 32'd5, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'd0, w);
      issue(6'd2, 32'd5, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'd1, w2);
      check("b2b_in_ready", 32'(w2), 32'd0);
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;

      // 3: shifts with backpressure
      out_ready = 1'b0;
      issue(6'd8, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 32'hF800_0000, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out", out, 32'hF800_0000);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(6'd15, 32'h8000_0000, 32'h0000_0024, 5'd0, 1'b1, 32'h0800_0000, w);
      issue(6'd11, 32'h0000_0003, 32'h0000_0021, 5'd0, 1'b1, 32'h0000_0006, w);
      issue(6'd7, 32'h8000_0000, 32'd0, 5'd31, 1'b1, 32'h0000_0001, w);

      // 4: multiply, latency and busy in_ready
      for (int k = 0; k < 2; k++) begin
         issue((k == 0) ? 6'd19 : 6'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1,
               (k == 0) ? 32'h0000_0001 : 32'hFFFF_FFFE, w);
         in1 = 32'd0; in2 = 32'd0;
         busy_ok = 1'b1;
         n = 0;
         while (n < 100) begin
            n++;
            @(posedge clk); #1;
            if (out_valid) break;
            if (in_ready !== 1'b0) busy_ok = 1'b0;
         end
         check("mul_latency", 32'(n), 32'd32);
         check("mul_busy_in_ready", {31'd0, busy_ok}, 32'd1);
      end
      @(posedge clk); #1;

      // 5: sticky exception
      issue(6'h3F, 32'd1, 32'd2, 5'd0, 1'b1, 32'd0, w);
      check("ill_latency", {31'd0, out_valid}, 32'd1);
      check("ill_x31", x31, 32'd2);
      issue(6'd9, 32'd1, 32'd1, 5'd0, 1'b1, 32'd2, w);
      check("x31_sticky", x31, 32'd2);
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      check("x31_cleared", x31, 32'd0);
      clear_err = 1'b1;
      issue(6'd21, 32'd1, 32'd2, 5'd0, 1'b1, 32'd0, w);
      clear_err = 1'b0;
      check("x31_clear_vs_ill", x31, 32'd2);
      @(posedge clk); #1;

      // 6: reset aborts multiply
      issue(6'd19, 32'd7, 32'd9, 5'd0, 1'b0, 32'd0, w);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_out", out, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_x31", x31, 32'd0);
      #3;
      reset = 1'b0;
      @(posedge clk); #1;
      issue(6'd0, 32'd3, 32'd4, 5'd0, 1'b1, 32'd7, w);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
